disp_arbiter: RTL and testbench



---
 rtl/disp_arbiter_pkg.sv | 12 +
 rtl/disp_pick.sv | 23 ++
 rtl/disp_arbiter.sv | 73 +++++++
 tb/tb_disp_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/disp_arbiter_pkg.sv
// disp_arbiter_pkg: shared widths, blank pattern, requester indices, FSM states and one-hot helper
package disp_arbiter_pkg;
  localparam int DW = 26;
  localparam logic [DW-1:0] BLANK = 26'h0DDDDDD;
  localparam int SRC_GAME = 0;
  localparam int SRC_SCORE = 1;
  localparam int SRC_BANNER = 2;
  typedef enum logic {IDLE, OWN} state_t;
  function automatic logic [2:0] lowest1h(input logic [2:0] r);
    return r & (~r + 3'd1);
  endfunction
endpackage

// File: rtl/disp_pick.sv
// disp_pick: next one-hot owner from requests, current owner and rotate mode
module disp_pick
  import disp_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] grant,
  input  logic       rotate,
  output logic [2:0] next
);
  logic [2:0] higher, rr;
  logic own_req, others;
  always_comb begin
    higher = req & (grant - 3'd1);
    own_req = |(req & grant);
    others = |(req & ~grant);
    rr = grant[SRC_GAME] ? (req[SRC_SCORE] ? 3'b010 : 3'b100) :
         grant[SRC_SCORE] ? (req[SRC_BANNER] ? 3'b100 : 3'b001) :
         (req[SRC_GAME] ? 3'b001 : 3'b010);
    next = (rotate && own_req && others) ? rr :
           |higher ? lowest1h(higher) :
           own_req ? grant : lowest1h(req);
  end
endmodule

// File: rtl/disp_arbiter.sv
// disp_arbiter: 3-source display bus arbiter with minimum hold; define ROTATE_EN for round-robin sharing
module disp_arbiter
  import disp_arbiter_pkg::*;
#(
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    req,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  input  logic [DW-1:0] data2,
  output logic [2:0]    grant,
  output logic [DW-1:0] display_q,
  output logic          hold_done
);
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);
`ifdef ROTATE_EN
  localparam logic ROTATE = 1'b1;
`else
  localparam logic ROTATE = 1'b0;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] nxt, grant_n;
  logic [DW-1:0] disp_n, own_data, nxt_data;
  logic done_n, arb;
  disp_pick u_pick (.req(req), .grant(grant), .rotate(ROTATE), .next(nxt));
  // arbitration only happens when idle or once the hold has expired
  always_comb begin
    own_data = grant[SRC_GAME] ? data0 : grant[SRC_SCORE] ? data1 : data2;
    nxt_data = nxt[SRC_GAME] ? data0 : nxt[SRC_SCORE] ? data1 : data2;
    arb = state == IDLE || hold_done;
    state_n = state;
    grant_n = grant;
    disp_n = display_q;
    cnt_n = cnt;
    done_n = hold_done;
    if (arb && nxt == 3'b000) begin
      state_n = IDLE;
      grant_n = 3'b000;
      disp_n = BLANK;
      cnt_n = '0;
      done_n = 1'b0;
    end else if (arb && nxt != grant) begin
      state_n = OWN;
      grant_n = nxt;
      disp_n = nxt_data;
      cnt_n = '0;
      done_n = LAST == '0;
    end else begin
      cnt_n = cnt == LAST ? cnt : cnt + 1'b1;
      done_n = cnt_n == LAST;
      disp_n = |(req & grant) ? own_data : display_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 3'b000;
      display_q <= BLANK;
      cnt <= '0;
      hold_done <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      display_q <= disp_n;
      cnt <= cnt_n;
      hold_done <= done_n;
    end
  end
endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: directed plus random stimulus against a behavioural owner/age model
module tb_disp_arbiter;
  localparam int H = 4;
  localparam logic [25:0] BLANK_W = 26'h0DDDDDD;
`ifdef ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [2:0] req;
  logic [25:0] data0, data1, data2;
  logic [2:0] grant;
  logic [25:0] display_q;
  logic hold_done;
  int n_checks = 0;
  int n_fail = 0;
  int owner = -1;
  int age = 0;
  logic [25:0] mdisp = BLANK_W;

  disp_arbiter #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1), .data2(data2),
    .grant(grant), .display_q(display_q), .hold_done(hold_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [25:0] dat(input int i);
    return i == 0 ? data0 : i == 1 ? data1 : data2;
  endfunction

  task automatic model_step();
    int nw;
    nw = -1;
    if (rst) begin
      owner = -1; age = 0; mdisp = BLANK_W;
      return;
    end
    if (owner < 0) begin
      for (int i = 2; i >= 0; i--) if (req[i]) nw = i;
      if (nw >= 0) begin owner = nw; age = 0; mdisp = dat(nw); end
      return;
    end
    if (age < H - 1) begin
      age++;
      if (req[owner]) mdisp = dat(owner);
      return;
    end
    if (ROT && req[owner] && (req & ~(3'b001 << owner)) != 3'b000) begin
      for (int k = 2; k >= 1; k--) if (req[(owner + k) % 3]) nw = (owner + k) % 3;
    end else begin
      for (int i = owner - 1; i >= 0; i--) if (req[i]) nw = i;
      if (nw < 0 && req[owner]) nw = owner;
      if (nw < 0) for (int i = 2; i >= 0; i--) if (req[i]) nw = i;
    end
    if (nw == owner) begin
      if (req[owner]) mdisp = dat(owner);
    end else if (nw < 0) begin
      owner = -1; age = 0; mdisp = BLANK_W;
    end else begin
      owner = nw; age = 0; mdisp = dat(nw);
    end
  endtask

  task automatic tick(input logic r, input logic [2:0] rq);
    rst = r;
    req = rq;
    @(posedge clk);
    model_step();
    #1;
    check("grant", 32'(grant), owner < 0 ? 32'd0 : 32'(3'b001 << owner));
    check("display_q", 32'(display_q), 32'(mdisp));
    check("hold_done", 32'(hold_done), 32'(owner >= 0 && age == H - 1));
  endtask

  initial begin
    rst = 1'b1; req = 3'b000;
    data0 = 26'h0AAAAAA; data1 = 26'h0BBBBBB; data2 = 26'h0123456;
    tick(1, 3'b000);
    tick(1, 3'b000);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_disp", 32'(display_q), 32'h0DDDDDD);
    tick(0, 3'b100);
    check("first_grant", 32'(grant), 32'b100);
    check("first_disp", 32'(display_q), 32'h0123456);
    for (int i = 0; i < 6; i++) tick(0, 3'b101);
    check("preempt", 32'(grant), 32'b001);
    tick(0, 3'b000);
    tick(0, 3'b000);
    for (int i = 0; i < 4; i++) tick(0, 3'b000);
    for (int i = 0; i < 14; i++) tick(0, 3'b011);
    for (int i = 0; i < 4; i++) tick(0, 3'b000);
    tick(0, 3'b010);
    for (int i = 0; i < 6; i++) begin
      data1 = 26'(i * 26'h0011111);
      tick(0, i == 0 ? 3'b010 : 3'b000);
    end
    tick(0, 3'b010);
    tick(0, 3'b010);
    tick(1, 3'b010);
    for (int i = 0; i < 6; i++) tick(0, 3'b010);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) req = 3'($urandom_range(7));
      data0 = 26'($urandom);
      data1 = 26'($urandom);
      data2 = 26'($urandom);
      tick($urandom_range(80) == 0, req);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
